// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states and
// the record latched when an operation is accepted.
package muldiv_pkg;

  localparam logic [1:0] OpMult  = 2'd0;
  localparam logic [1:0] OpMultu = 2'd1;
  localparam logic [1:0] OpDiv   = 2'd2;
  localparam logic [1:0] OpDivu  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  // Per-operation control captured at acceptance.
  // fault: divide by zero, or a divide request when no divider is built.
  typedef struct packed {
    logic is_div;
    logic neg1;
    logic neg2;
    logic fault;
  } op_rec_t;

  // Signed ops work on magnitudes and get their sign restored afterwards.
  function automatic logic op_is_signed(input logic [1:0] op);
    logic s;
    s = 1'b0;
    unique case (op)
      OpMult, OpDiv:   s = 1'b1;
      OpMultu, OpDivu: s = 1'b0;
      default:         s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. The divide path exists only when MULDIV_DIV_EN is defined.
//
// Multiply: {hi,lo} holds partial product in hi and remaining multiplier in lo.
// Divide:   hi holds the partial remainder, lo shifts dividend out / quotient in.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
`endif

  // Combinational single-step datapath.
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh = {hi_i, lo_i[WIDTH-1]};
    ge     = rem_sh >= {1'b0, b_i};
    // When ge holds the true difference is below b_i, so modulo-2^WIDTH is exact.
    diff   = rem_sh[WIDTH-1:0] - b_i;
    if (is_div_i) begin
      hi_o = ge ? diff : rem_sh[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU), one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU complete one
// cycle after acceptance with err set and hi/lo untouched.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FWD_CANCEL = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned    CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  state_e           state_q;
  op_rec_t          rec_q;
  logic [WIDTH-1:0] hi_acc_q, lo_acc_q, b_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q, err_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             accept, is_div_op, start_fault, neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  // Acceptance qualification and operand magnitudes.
  always_comb begin
    accept    = (state_q == StIdle) && start && !(cancel && (FWD_CANCEL != 0));
    is_div_op = op_is_div(op);
    neg1      = op_is_signed(op) && src1[WIDTH-1];
    neg2      = op_is_signed(op) && src2[WIDTH-1];
    mag1      = neg1 ? ('0 - src1) : src1;
    mag2      = neg2 ? ('0 - src2) : src2;
`ifdef MULDIV_DIV_EN
    start_fault = is_div_op && (src2 == '0);
`else
    start_fault = is_div_op;
`endif
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
`ifdef MULDIV_DIV_EN
    .is_div_i (rec_q.is_div),
`endif
    .hi_i     (hi_acc_q),
    .lo_i     (lo_acc_q),
    .b_i      (b_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Sign correction of the magnitude result, applied in FIX.
  always_comb begin
    prod_neg = '0 - {hi_acc_q, lo_acc_q};
    fix_hi   = hi_acc_q;
    fix_lo   = lo_acc_q;
    if (!rec_q.is_div) begin
      if (rec_q.neg1 ^ rec_q.neg2) {fix_hi, fix_lo} = prod_neg;
    end
`ifdef MULDIV_DIV_EN
    else begin
      // Quotient takes the xor of operand signs, remainder the dividend sign.
      // Most-negative / -1 yields quotient magnitude 2^(WIDTH-1) unnegated,
      // which already reads as the most-negative value.
      if (rec_q.neg1 ^ rec_q.neg2) fix_lo = '0 - lo_acc_q;
      if (rec_q.neg1)              fix_hi = '0 - hi_acc_q;
    end
`endif
  end

  // Control FSM with registered busy/done/err/hi/lo.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      rec_q    <= '0;
      hi_acc_q <= '0;
      lo_acc_q <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rec_q    <= '{is_div: is_div_op, neg1: neg1, neg2: neg2, fault: start_fault};
            b_q      <= mag2;
            cnt_q    <= '0;
`ifdef MULDIV_DIV_EN
            // Divide by zero bypasses RUN; FIX passes these values through.
            hi_acc_q <= start_fault ? src1 : '0;
            lo_acc_q <= start_fault ? '1 : mag1;
            state_q  <= start_fault ? StFix : StRun;
            busy_q   <= 1'b1;
`else
            hi_acc_q <= '0;
            lo_acc_q <= mag1;
            state_q  <= start_fault ? StDone : StRun;
            busy_q   <= !start_fault;
`endif
          end
        end
        StRun: begin
          if (cancel) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            hi_acc_q <= step_hi;
            lo_acc_q <= step_lo;
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == LastIter) state_q <= StFix;
          end
        end
        StFix: begin
          busy_q <= 1'b0;
          if (cancel) begin
            state_q <= StIdle;
          end else begin
            if (!rec_q.fault) begin
              hi_acc_q <= fix_hi;
              lo_acc_q <= fix_lo;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
          err_q   <= rec_q.fault;
`ifdef MULDIV_DIV_EN
          hi_q    <= hi_acc_q;
          lo_q    <= lo_acc_q;
`else
          // Unsupported divide leaves the visible result untouched.
          if (!rec_q.fault) begin
            hi_q <= hi_acc_q;
            lo_q <= lo_acc_q;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32). Expected results come from a
// behavioural model or fixed vectors, queued at issue and popped at done.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic         busy, done, err;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] last_hi = '0, last_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH      (W),
    .FWD_CANCEL (1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .hi     (hi),
    .lo     (lo)
  );

  // err must never be high without done.
  always @(negedge clk) begin
    if (resetn && !done) begin
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL err_without_done: err=%b required 0", err);
      end
    end
  end

  function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic e,
                              input int lat);
    exp_t r;
    r.hi = h; r.lo = l; r.err = e; r.lat = lat;
    return r;
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t        e;
    longint      sp;
    logic [63:0] up;
    e.err = 1'b0;
    e.lat = W + 2;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {e.hi, e.lo} = sp;
      end
      MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {e.hi, e.lo} = up;
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.err = 1'b1; e.lat = 2;
        end else if (o == DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = '0; e.lo = 32'h8000_0000;
        end else if (o == DIV) begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
`else
        e.hi = last_hi; e.lo = last_lo; e.err = 1'b1; e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e);
    op = o; src1 = a; src2 = b; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen or the limit expires; no comparisons here.
  task automatic wait_done(input int limit, output int lat, output bit seen);
    lat = 0; seen = 1'b0;
    while (!seen && lat < limit) begin
      @(negedge clk);
      lat++;
      seen = done;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h required 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h required 0", lo); end
    resetn = 1'b1;  // next task starts on this same negedge
  endtask

  task automatic test_mult();
    int lat; bit seen; exp_t e;
    logic [W-1:0] a, b; logic [1:0] o;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        o = MULT; a = 32'hFFFF_FFFD; b = 32'h0000_0007;
        issue(o, a, b, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34));
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b required 1", busy); end
      end else begin
        o = i[0] ? MULTU : MULT;
        a = (i == 2) ? 32'h8000_0000 : $urandom;
        b = (i == 2) ? 32'h8000_0000 : $urandom;
        issue(o, a, b, model(o, a, b));
      end
      wait_done(W + 10, lat, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != e.lat) begin
        errors++; $display("FAIL mult%0d_latency: got %0d seen=%0b required %0d", i, lat, seen, e.lat);
      end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL mult%0d_hi: got %h required %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL mult%0d_lo: got %h required %h", i, lo, e.lo); end
      checks++; if (err !== e.err) begin errors++; $display("FAIL mult%0d_err: got %b required %b", i, err, e.err); end
      last_hi = e.hi; last_lo = e.lo;
    end
  endtask

  task automatic test_busy_start();
    int lat; bit seen, extra; exp_t e;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, W + 2 - 5));
    repeat (4) @(negedge clk);
    op = MULT; src1 = 32'd5; src2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(W + 10, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++; $display("FAIL busy_start_latency: got %0d seen=%0b required %0d", lat, seen, e.lat);
    end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL busy_start_hi: got %h required %h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL busy_start_lo: got %h required %h", lo, e.lo); end
    last_hi = e.hi; last_lo = e.lo;
    extra = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL busy_start_extra_done: got %b required 0", extra); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int lat; bit seen; exp_t e;
    logic [W-1:0] a, b; logic [1:0] o;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin o = DIV; a = 32'hFFFF_FFF9; b = 32'd2;
             issue(o, a, b, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 2)); end
        1: begin o = DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
             issue(o, a, b, mk(32'h0000_0000, 32'h8000_0000, 1'b0, W + 2)); end
        2: begin o = DIVU; a = 32'h0000_0064; b = 32'd0;
             issue(o, a, b, mk(32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2)); end
        3: begin o = DIV; a = 32'hFFFF_FF00; b = 32'd0; issue(o, a, b, model(o, a, b)); end
        default: begin
          o = i[0] ? DIVU : DIV;
          a = $urandom;
          b = (i > 5) ? $urandom_range(1, 1000) : $urandom;
          if (b == '0) b = 32'd3;
          issue(o, a, b, model(o, a, b));
        end
      endcase
      wait_done(W + 10, lat, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != e.lat) begin
        errors++; $display("FAIL div%0d_latency: got %0d seen=%0b required %0d", i, lat, seen, e.lat);
      end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL div%0d_hi: got %h required %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL div%0d_lo: got %h required %h", i, lo, e.lo); end
      checks++; if (err !== e.err) begin errors++; $display("FAIL div%0d_err: got %b required %b", i, err, e.err); end
      last_hi = e.hi; last_lo = e.lo;
    end
  endtask
`else
  task automatic test_div_disabled();
    int lat; bit seen; exp_t e;
    issue(DIVU, 32'd10, 32'd3, mk(last_hi, last_lo, 1'b1, 1));
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nodiv_busy: got %b required 0", busy); end
    wait_done(W + 10, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++; $display("FAIL nodiv_latency: got %0d seen=%0b required %0d", lat, seen, e.lat);
    end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL nodiv_hi: got %h required %h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL nodiv_lo: got %h required %h", lo, e.lo); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL nodiv_err: got %b required %b", err, e.err); end
  endtask
`endif

  task automatic test_cancel();
    int lat; bit seen, any_done; exp_t e;
    op = MULTU; src1 = 32'h1234_5678; src2 = 32'h0000_0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b required 0", busy); end
    any_done = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    checks++; if (any_done !== 1'b0) begin errors++; $display("FAIL cancel_done: got %b required 0", any_done); end
    checks++; if (hi !== last_hi) begin errors++; $display("FAIL cancel_hi: got %h required %h", hi, last_hi); end
    checks++; if (lo !== last_lo) begin errors++; $display("FAIL cancel_lo: got %h required %h", lo, last_lo); end
    // Start together with cancel in IDLE must be suppressed.
    op = MULT; src1 = 32'd9; src2 = 32'd9; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fwd_cancel_busy: got %b required 0", busy); end
    wait_done(W + 5, lat, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL fwd_cancel_done: got %b required 0", seen); end
    // The unit must still work normally afterwards.
    issue(MULT, 32'hFFFF_FFFF, 32'h0000_0003, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 2));
    wait_done(W + 10, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++; $display("FAIL after_cancel_latency: got %0d seen=%0b required %0d", lat, seen, e.lat);
    end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL after_cancel_hi: got %h required %h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL after_cancel_lo: got %h required %h", lo, e.lo); end
    last_hi = e.hi; last_lo = e.lo;
  endtask

  task automatic test_reset_mid();
    int lat; bit seen;
    op = MULT; src1 = 32'h0000_1234; src2 = 32'h0000_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b required 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b required 0", err); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL midrst_hi: got %h required 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL midrst_lo: got %h required 0", lo); end
    @(negedge clk);
    resetn = 1'b1;
    last_hi = '0; last_lo = '0;
    wait_done(W + 5, lat, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_late_done: got %b required 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat; bit seen; exp_t e;
    logic [W-1:0] a, b; logic [1:0] o;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? '0 : $urandom;
      issue(o, a, b, model(o, a, b));
      wait_done(W + 10, lat, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != e.lat) begin
        errors++; $display("FAIL b2b%0d_latency: op=%0d got %0d seen=%0b required %0d", i, o, lat, seen, e.lat);
      end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL b2b%0d_hi: op=%0d got %h required %h", i, o, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL b2b%0d_lo: op=%0d got %h required %h", i, o, lo, e.lo); end
      checks++; if (err !== e.err) begin errors++; $display("FAIL b2b%0d_err: op=%0d got %b required %b", i, o, err, e.err); end
      last_hi = e.hi; last_lo = e.lo;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_busy_start();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (even, >=8).
REQ-002 Parameter FWD_CANCEL, default 1, when 1 a cancel in the start cycle suppresses the start.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  operation: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-007 src1  input  WIDTH  multiplicand or dividend.
REQ-008 src2  input  WIDTH  multiplier or divisor.
REQ-009 cancel  input  1  pipeline flush (exception or eret); aborts the operation in flight.
REQ-010 busy  output  1  high in RUN and FIX.
REQ-011 done  output  1  one-cycle pulse when hi/lo are valid.
REQ-012 err  output  1  qualified by done; divide by zero or unsupported op.
REQ-013 hi  output  WIDTH  product upper half, or remainder.
REQ-014 lo  output  WIDTH  product lower half, or quotient.

Function
REQ-015 FSM states: IDLE, RUN, FIX, DONE; IDLE->RUN on accepted start; RUN->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-016 Start accepted only when state==IDLE and start=1 and not (cancel=1 and FWD_CANCEL=1); operands and op latched on acceptance; start in other states ignored.
REQ-017 Signed ops (MULT, DIV) operate on magnitudes; sign correction applied in FIX.
REQ-018 Multiply: radix-2 shift-add, one bit per RUN cycle, 2*WIDTH-bit result, {hi,lo}=full product.
REQ-019 Divide: radix-2 restoring, one quotient bit per RUN cycle; quotient sign = sign(src1) xor sign(src2); remainder sign = sign(src1).
REQ-020 Latency: done=1 exactly WIDTH+2 cycles after the accepting edge; hi/lo updated on the same edge done rises.
REQ-021 hi/lo hold their value until the next done; cancelled operations never modify them.
REQ-022 Divide by zero: skip RUN (IDLE->FIX->DONE), lo=all ones, hi=src1, err=1.
REQ-023 Signed overflow (DIV, src1=most-negative, src2=-1): lo=most-negative, hi=0, err=0.
REQ-024 cancel=1 in RUN or FIX: next state IDLE, no done, busy low next cycle; cancel in DONE has no effect on the pulse.
REQ-025 err=0 whenever done=0.

Reset
REQ-026 resetn=0 forces state IDLE, busy=0, done=0, err=0, hi=0, lo=0 immediately, including mid-operation.
REQ-027 First start is accepted on the first rising edge after resetn deasserts.

Configuration
REQ-028 Macro MULDIV_DIV_EN: when defined, DIV/DIVU are implemented per REQ-019, REQ-022 and REQ-023.
REQ-029 Without MULDIV_DIV_EN: DIV/DIVU take IDLE->DONE, done one cycle after acceptance, err=1, hi/lo unchanged; no divider logic is synthesised.

Structure
REQ-030 Shared package muldiv_pkg holds the op encoding constants, the FSM state enum and the operand-record typedef.
REQ-031 The iteration datapath (one shift-add or shift-subtract step) is the sub-module muldiv_step, instantiated once.
REQ-032 All remaining control and sign-fix logic lives in muldiv_unit.

Verification (WIDTH=32, MULDIV_DIV_EN defined unless stated)
REQ-033 MULT src1=FFFFFFFD, src2=00000007 -> done at edge 34 after accept, hi=FFFFFFFF, lo=FFFFFFEB, err=0.
REQ-034 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; start pulsed during busy is ignored.
REQ-035 DIV 0xFFFFFFF9 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0, err=0.
REQ-036 DIVU 00000064 / 0 -> done 2 cycles after accept, lo=FFFFFFFF, hi=00000064, err=1.
REQ-037 cancel at RUN cycle 10 -> no done, busy=0 next cycle, hi/lo keep prior value; next start completes normally; resetn pulse mid-RUN clears all outputs.
REQ-038 Built without MULDIV_DIV_EN: DIVU 10/3 -> done one cycle after accept, err=1, hi/lo unchanged.
